wresp_rr_router: RTL

Parametrised AXI write-response (B channel) router between NUM_S slave ports and NUM_M master ports. It accepts one B beat at a time from the slaves, using round-robin arbitration. The beat goes into a one-entry holding register and is forwarded to the master whose index sits in the upper field of the slave-side BID. Out-of-range master indices are absorbed and flagged. The block sits in the AXI bus fabric between the slave-side response outputs and the master-side B channels.

---
 rtl/wresp_rr_router_if.sv | 14 +
 rtl/wresp_rr_router.sv | 65 ++++++
 2 files changed

// File: rtl/wresp_rr_router_if.sv
// wresp_rr_router_if: slave-side and master-side AXI B channels of the router
interface wresp_rr_router_if #(parameter int NUM_S = 3, NUM_M = 2, ID_BITS = 4, MIDX_BITS = 4);
  localparam int SID_BITS = MIDX_BITS + ID_BITS;
  logic [NUM_S*SID_BITS-1:0] S_BID;
  logic [NUM_S*2-1:0] S_BResp;
  logic [NUM_S-1:0] S_BValid;
  logic [NUM_S-1:0] S_BReady;
  logic [NUM_M*ID_BITS-1:0] M_BID;
  logic [NUM_M*2-1:0] M_BResp;
  logic [NUM_M-1:0] M_BValid;
  logic [NUM_M-1:0] M_BReady;
  modport slave (input S_BID, S_BResp, S_BValid, M_BReady, output S_BReady, M_BID, M_BResp, M_BValid);
  modport master (output S_BID, S_BResp, S_BValid, M_BReady, input S_BReady, M_BID, M_BResp, M_BValid);
endinterface

// File: rtl/wresp_rr_router.sv
// wresp_rr_router: round-robin AXI B-channel router with a one-entry holding register
module wresp_rr_router #(parameter int NUM_S = 3, NUM_M = 2, ID_BITS = 4, MIDX_BITS = 4) (
  input  logic clk,
  input  logic rst,
  wresp_rr_router_if.slave b,
  output logic dec_err
);
  localparam int SID_BITS = MIDX_BITS + ID_BITS;
  localparam int PW = $clog2(NUM_S);
  typedef enum logic {IDLE, SEND} state_t;
  state_t st, nxt;
  logic [PW-1:0] ptr;
  logic [ID_BITS-1:0] hold_id;
  logic [1:0] hold_resp;
  logic [MIDX_BITS-1:0] hold_midx;
  logic found, in_range, take, ack, sel;
  int g;
  logic [SID_BITS-1:0] g_bid;
  logic [1:0] g_resp;
  always_comb begin
    found = 1'b0;
    g = 0;
    for (int i = 0; i < NUM_S; i++)
      if (!found && b.S_BValid[(int'(ptr) + i) % NUM_S]) begin
        found = 1'b1;
        g = (int'(ptr) + i) % NUM_S;
      end
  end
  assign g_bid = b.S_BID[g*SID_BITS +: SID_BITS];
  assign g_resp = b.S_BResp[2*g +: 2];
  assign in_range = 32'(g_bid[SID_BITS-1:ID_BITS]) < 32'(NUM_M);
  // no grant while reset is asserted, so a slave never sees a handshake that gets discarded
  assign take = rst && st == IDLE && found;
  assign ack = |(b.M_BValid & b.M_BReady);
  always_ff @(posedge clk)
    if (!rst) st <= IDLE;
    else st <= nxt;
  always_comb nxt = st == IDLE ? ((take && in_range) ? SEND : IDLE) : (ack ? IDLE : SEND);
  always_ff @(posedge clk)
    if (!rst) begin
      ptr <= '0;
      hold_id <= '0;
      hold_resp <= '0;
      hold_midx <= '0;
      dec_err <= 1'b0;
    end else begin
      dec_err <= take && !in_range;
      if (take) begin
        hold_id <= g_bid[ID_BITS-1:0];
        hold_midx <= g_bid[SID_BITS-1:ID_BITS];
        hold_resp <= g_resp;
        ptr <= PW'((g + 1) % NUM_S);
      end
    end
  always_comb begin
    sel = 1'b0;
    b.S_BReady = take ? NUM_S'(1) << g : '0;
    for (int m = 0; m < NUM_M; m++) begin
      sel = st == SEND && 32'(hold_midx) == m;
      b.M_BValid[m] = sel;
      b.M_BID[m*ID_BITS +: ID_BITS] = sel ? hold_id : '0;
      b.M_BResp[m*2 +: 2] = sel ? hold_resp : 2'b00;
    end
  end
endmodule
